// File: rtl/vga_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ==== vga_monitor : VGA sink -- sync timing measurement, lock tracking, per-frame pixel checksum ====
// Rev 1.0
module vga_monitor #(
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2,
  parameter int HS_TIMEOUT  = 4095
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [4:0]  vga_r,
  input  logic [5:0]  vga_g,
  input  logic [4:0]  vga_b,
  output logic [11:0] h_total,
  output logic [11:0] h_sync_w,
  output logic [10:0] v_total,
  output logic [10:0] v_sync_w,
  output logic [23:0] pixel_sum,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [11:0] c_HCNT_MAX = 12'hFFF;
  localparam logic [10:0] c_VCNT_MAX = 11'h7FF;
  localparam logic [11:0] c_TIMEOUT  = 12'(HS_TIMEOUT);
  localparam logic [3:0]  c_LOCK     = 4'(LOCK_FRAMES);

  state_t      r_state, w_state_nx;
  logic        r_hs_a, r_hs_b, r_vs_a, r_vs_b;
  logic [4:0]  r_r, r_b;
  logic [5:0]  r_g;
  logic [11:0] r_hcnt, r_hper, r_hsw_cnt, r_hsw_meas;
  logic [10:0] r_vcnt, r_vsw_cnt;
  logic [23:0] r_acc;
  logic [3:0]  r_match, w_match_nx, w_match_inc;
  logic        r_have_base, w_base_nx, r_to_fired;
  logic        w_upd, w_err;

  logic        w_hs_a_on, w_hs_b_on, w_vs_a_on, w_vs_b_on;
  logic        w_hs_rise, w_hs_fall, w_vs_rise;
  logic [11:0] w_hcnt_inc, w_line_per;
  logic [10:0] w_vcnt_inc, w_vtot;
  logic [23:0] w_pix, w_sum_tot;
  logic        w_timeout, w_to_pulse, w_same, w_hs_bad;

  assign w_hs_a_on = (r_hs_a == SYNC_POL);
  assign w_hs_b_on = (r_hs_b == SYNC_POL);
  assign w_vs_a_on = (r_vs_a == SYNC_POL);
  assign w_vs_b_on = (r_vs_b == SYNC_POL);
  assign w_hs_rise = w_hs_a_on & ~w_hs_b_on;
  assign w_hs_fall = ~w_hs_a_on & w_hs_b_on;
  assign w_vs_rise = w_vs_a_on & ~w_vs_b_on;

  assign w_hcnt_inc = (r_hcnt == c_HCNT_MAX) ? r_hcnt : r_hcnt + 12'd1;
  assign w_line_per = w_hs_rise ? r_hcnt : r_hper;
  assign w_vcnt_inc = (r_vcnt == c_VCNT_MAX) ? r_vcnt : r_vcnt + 11'd1;
  // A line starting on the same cycle as vsync belongs to the frame that is ending.
  assign w_vtot     = w_hs_rise ? w_vcnt_inc : r_vcnt;
  assign w_pix      = 24'(r_r) + 24'(r_g) + 24'(r_b);
  assign w_sum_tot  = r_acc + w_pix;

  // An hs edge this cycle proves the link is alive even if hcnt is saturated.
  assign w_timeout   = (r_hcnt >= c_TIMEOUT) & ~w_hs_rise;
  assign w_to_pulse  = w_timeout & (~r_to_fired | (r_state != SEARCH));
  assign w_same      = (w_line_per == h_total) && (w_vtot == v_total);
  assign w_hs_bad    = w_hs_rise && (r_hcnt != h_total);
  assign w_match_inc = r_match + 4'd1;
  assign locked      = (r_state == LOCKED);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_a <= ~SYNC_POL;
      r_hs_b <= ~SYNC_POL;
      r_vs_a <= ~SYNC_POL;
      r_vs_b <= ~SYNC_POL;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
    end else begin
      r_hs_a <= vga_hs;
      r_hs_b <= r_hs_a;
      r_vs_a <= vga_vs;
      r_vs_b <= r_vs_a;
      r_r    <= vga_r;
      r_g    <= vga_g;
      r_b    <= vga_b;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt     <= '0;
      r_hper     <= '0;
      r_hsw_cnt  <= '0;
      r_hsw_meas <= '0;
      r_vcnt     <= '0;
      r_vsw_cnt  <= '0;
      r_acc      <= '0;
    end else begin
      r_hcnt <= w_hs_rise ? 12'd1 : w_hcnt_inc;
      if (w_hs_rise) r_hper <= r_hcnt;

      if (w_hs_rise)
        r_hsw_cnt <= 12'd1;
      else if (w_hs_a_on && (r_hsw_cnt != c_HCNT_MAX))
        r_hsw_cnt <= r_hsw_cnt + 12'd1;
      if (w_hs_fall) r_hsw_meas <= r_hsw_cnt;

      if (w_vs_rise)
        r_vcnt <= '0;
      else if (w_hs_rise)
        r_vcnt <= w_vcnt_inc;

      if (w_vs_rise)
        r_vsw_cnt <= w_hs_rise ? 11'd1 : 11'd0;
      else if (w_hs_rise && w_vs_a_on && (r_vsw_cnt != c_VCNT_MAX))
        r_vsw_cnt <= r_vsw_cnt + 11'd1;

      r_acc <= w_vs_rise ? 24'd0 : w_sum_tot;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total    <= '0;
      h_sync_w   <= '0;
      v_total    <= '0;
      v_sync_w   <= '0;
      pixel_sum  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= w_upd;
      sync_err   <= w_err;
      if (w_upd) begin
        h_total   <= w_line_per;
        h_sync_w  <= r_hsw_meas;
        v_total   <= w_vtot;
        v_sync_w  <= r_vsw_cnt;
        pixel_sum <= w_sum_tot;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SEARCH;
      r_match     <= '0;
      r_have_base <= 1'b0;
      r_to_fired  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_match     <= w_match_nx;
      r_have_base <= w_base_nx;
      if (w_to_pulse)
        r_to_fired <= 1'b1;
      else if (r_state != SEARCH)
        r_to_fired <= 1'b0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_match_nx = r_match;
    w_base_nx  = r_have_base;
    w_upd      = 1'b0;
    w_err      = 1'b0;
    unique case (r_state)
      SEARCH: begin
        if (w_vs_rise) begin
          w_state_nx = MEASURE;
          w_match_nx = '0;
          w_base_nx  = 1'b0;
        end
      end
      MEASURE: begin
        if (w_vs_rise) begin
          w_upd = 1'b1;
          if (!r_have_base) begin
            w_base_nx  = 1'b1;
            w_match_nx = '0;
          end else if (w_same) begin
            w_match_nx = w_match_inc;
            if (w_match_inc >= c_LOCK) w_state_nx = LOCKED;
          end else begin
            w_match_nx = '0;
          end
        end
      end
      LOCKED: begin
        if (w_vs_rise) w_upd = 1'b1;
        if (w_hs_bad || (w_vs_rise && (w_vtot != v_total))) begin
          w_state_nx = SEARCH;
          w_err      = 1'b1;
        end
      end
      default: w_state_nx = SEARCH;
    endcase
    if (w_timeout) begin
      w_state_nx = SEARCH;
      w_err      = w_err | w_to_pulse;
    end
  end

endmodule
`default_nettype wire
